// File: rtl/elevator_scan_ctrl.sv
// Single-car SCAN elevator controller: latched hall/car calls, timed travel and door dwell.
// Optional fire-service recall is compiled in when FIRE_RECALL_EN is defined.
module elevator_scan_ctrl #(
    parameter int unsigned NUM_FLOORS    = 8,
    parameter int unsigned FLOOR_W       = 3,
    parameter int unsigned TRAVEL_CYCLES = 10,
    parameter int unsigned DOOR_CYCLES   = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] move_up_call,
    input  logic [NUM_FLOORS-1:0] move_down_call,
    input  logic [NUM_FLOORS-1:0] req_floor,
    input  logic                  over_weight,
    input  logic                  open_door,
    input  logic                  close_door,
`ifdef FIRE_RECALL_EN
    input  logic                  fire_recall,
`endif
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [1:0]            direction,
    output logic                  door_state,
    output logic                  over_weight_alert,
    output logic [NUM_FLOORS-1:0] pending_calls
);

    localparam int unsigned TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int unsigned DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0]      TravelLast = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0]      DwellLast  = DW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TopFloor   = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [1:0]         DirIdle    = 2'b00;
    localparam logic [1:0]         DirUp      = 2'b01;
    localparam logic [1:0]         DirDown    = 2'b10;

    typedef enum logic [1:0] {StIdle, StMoving, StDoorOpen, StOverload} state_e;

    state_e                state;
    logic                  last_up;
    logic [TW-1:0]         travel_cnt;
    logic [DW-1:0]         dwell_cnt;
    logic [NUM_FLOORS-1:0] pend_up, pend_dn, pend_car;

    logic                  fire;
    logic [NUM_FLOORS-1:0] up_in, dn_in, car_in, call_in, pend;
    logic [NUM_FLOORS-1:0] lat_up, lat_dn, lat_car, keep_cur, keep_next;
    logic [FLOOR_W-1:0]    next_floor;
    logic                  open_req, close_req, call_here, pend_here;
    logic                  ahead_cur, behind_cur, ahead_next, stop_next;

`ifdef FIRE_RECALL_EN
    assign fire = fire_recall;
`else
    assign fire = 1'b0;
`endif

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] v,
                                       input logic [FLOOR_W-1:0]    f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (i > int'(f)) r = r | v[i];
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] v,
                                       input logic [FLOOR_W-1:0]    f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (i < int'(f)) r = r | v[i];
        end
        return r;
    endfunction

    assign pend          = pend_up | pend_dn | pend_car;
    assign pending_calls = pend;

    always_comb begin
        up_in  = move_up_call;
        dn_in  = move_down_call;
        car_in = req_floor;
        // No up call from the top floor, no down call from the bottom floor.
        up_in[NUM_FLOORS-1] = 1'b0;
        dn_in[0]            = 1'b0;
        if (fire) begin
            up_in  = '0;
            dn_in  = '0;
            car_in = '0;
        end
        open_req  = open_door & ~fire;
        close_req = close_door & ~fire;
        call_in   = up_in | dn_in | car_in;
        lat_up    = fire ? '0 : (pend_up | up_in);
        lat_dn    = fire ? '0 : (pend_dn | dn_in);
        lat_car   = fire ? '0 : (pend_car | car_in);

        if (last_up) begin
            next_floor = (current_floor == TopFloor) ? current_floor : current_floor + 1'b1;
        end else begin
            next_floor = (current_floor == '0) ? current_floor : current_floor - 1'b1;
        end
        keep_cur  = ~(NUM_FLOORS'(1) << current_floor);
        keep_next = ~(NUM_FLOORS'(1) << next_floor);

        call_here  = call_in[current_floor];
        pend_here  = pend[current_floor];
        ahead_cur  = last_up ? any_above(pend, current_floor) : any_below(pend, current_floor);
        behind_cur = last_up ? any_below(pend, current_floor) : any_above(pend, current_floor);
        ahead_next = last_up ? any_above(pend, next_floor) : any_below(pend, next_floor);
        // Opposite-direction hall calls are served only at the end of the sweep.
        stop_next  = pend_car[next_floor]
                   | (last_up ? pend_up[next_floor] : pend_dn[next_floor])
                   | (pend[next_floor] & ~ahead_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= StIdle;
            last_up           <= 1'b1;
            current_floor     <= '0;
            direction         <= DirIdle;
            door_state        <= 1'b0;
            over_weight_alert <= 1'b0;
            travel_cnt        <= '0;
            dwell_cnt         <= '0;
            pend_up           <= '0;
            pend_dn           <= '0;
            pend_car          <= '0;
        end else begin
            pend_up  <= lat_up;
            pend_dn  <= lat_dn;
            pend_car <= lat_car;
            unique case (state)
                StIdle: begin
                    if (fire ? (current_floor == '0) : (pend_here || open_req)) begin
                        state      <= StDoorOpen;
                        door_state <= 1'b1;
                        dwell_cnt  <= '0;
                        pend_up    <= lat_up & keep_cur;
                        pend_dn    <= lat_dn & keep_cur;
                        pend_car   <= lat_car & keep_cur;
                    end else if (fire || ahead_cur) begin
                        state      <= StMoving;
                        travel_cnt <= '0;
                        last_up    <= last_up & ~fire;
                        direction  <= (last_up && !fire) ? DirUp : DirDown;
                    end else if (behind_cur) begin
                        state      <= StMoving;
                        travel_cnt <= '0;
                        last_up    <= ~last_up;
                        direction  <= last_up ? DirDown : DirUp;
                    end
                end
                StMoving: begin
                    if (fire && last_up) begin
                        // Recall reverses the car; it restarts from the floor it last passed.
                        last_up    <= 1'b0;
                        direction  <= DirDown;
                        travel_cnt <= '0;
                    end else if (travel_cnt == TravelLast) begin
                        travel_cnt    <= '0;
                        current_floor <= next_floor;
                        if (fire ? (next_floor == '0) : stop_next) begin
                            state      <= StDoorOpen;
                            door_state <= 1'b1;
                            dwell_cnt  <= '0;
                            pend_up    <= lat_up & keep_next;
                            pend_dn    <= lat_dn & keep_next;
                            pend_car   <= lat_car & keep_next;
                        end else if (!fire && !ahead_next) begin
                            state     <= StIdle;
                            direction <= DirIdle;
                        end
                    end else begin
                        travel_cnt <= travel_cnt + 1'b1;
                    end
                end
                StDoorOpen: begin
                    if (fire && current_floor != '0) begin
                        state      <= StIdle;
                        door_state <= 1'b0;
                        direction  <= DirIdle;
                    end else if (over_weight) begin
                        state             <= StOverload;
                        over_weight_alert <= 1'b1;
                    end else if (fire || open_req || call_here) begin
                        dwell_cnt <= '0;
                        pend_up   <= lat_up & keep_cur;
                        pend_dn   <= lat_dn & keep_cur;
                        pend_car  <= lat_car & keep_cur;
                    end else if (close_req || dwell_cnt == DwellLast) begin
                        state      <= StIdle;
                        door_state <= 1'b0;
                        direction  <= DirIdle;
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                StOverload: begin
                    if (fire && current_floor != '0) begin
                        state             <= StIdle;
                        door_state        <= 1'b0;
                        over_weight_alert <= 1'b0;
                        direction         <= DirIdle;
                    end else if (!over_weight) begin
                        state             <= StDoorOpen;
                        over_weight_alert <= 1'b0;
                        dwell_cnt         <= '0;
                        pend_up           <= lat_up & keep_cur;
                        pend_dn           <= lat_dn & keep_cur;
                        pend_car          <= lat_car & keep_cur;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed scenarios for elevator_scan_ctrl (8 floors, 10-cycle travel, 20-cycle dwell);
// expected stop floors are queued with the stimulus and checked on each door opening.
`timescale 1ns/1ps
module tb_elevator_scan_ctrl;

    localparam int NF = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NF-1:0] move_up_call   = '0;
    logic [NF-1:0] move_down_call = '0;
    logic [NF-1:0] req_floor      = '0;
    logic          over_weight    = 1'b0;
    logic          open_door      = 1'b0;
    logic          close_door     = 1'b0;
`ifdef FIRE_RECALL_EN
    logic          fire_recall    = 1'b0;
`endif
    logic [2:0]    current_floor;
    logic [1:0]    direction;
    logic          door_state;
    logic          over_weight_alert;
    logic [NF-1:0] pending_calls;

    int total = 0;
    int bad   = 0;
    int sb[$];

    always #5 clk = ~clk;

    elevator_scan_ctrl #(
        .NUM_FLOORS   (8),
        .FLOOR_W      (3),
        .TRAVEL_CYCLES(10),
        .DOOR_CYCLES  (20)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .move_up_call     (move_up_call),
        .move_down_call   (move_down_call),
        .req_floor        (req_floor),
        .over_weight      (over_weight),
        .open_door        (open_door),
        .close_door       (close_door),
`ifdef FIRE_RECALL_EN
        .fire_recall      (fire_recall),
`endif
        .current_floor    (current_floor),
        .direction        (direction),
        .door_state       (door_state),
        .over_weight_alert(over_weight_alert),
        .pending_calls    (pending_calls)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every door opening pops the next expected stop floor.
    initial begin : stop_monitor
        logic door_prev;
        door_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (door_state && !door_prev) begin
                chk("stop_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) chk("stop_floor", 32'(current_floor), sb.pop_front());
            end
            door_prev = door_state;
        end
    end

    initial begin
        step(2);
        chk("rst_floor", 32'(current_floor), 0);
        chk("rst_dir", 32'(direction), 0);
        chk("rst_door", 32'(door_state), 0);
        chk("rst_alert", 32'(over_weight_alert), 0);
        chk("rst_pend", 32'(pending_calls), 0);
        rst = 1'b0;

        // Masked corner calls never latch.
        move_up_call = 8'h80; move_down_call = 8'h01;
        step(1);
        move_up_call = '0; move_down_call = '0;
        chk("mask_pend", 32'(pending_calls), 0);
        step(5);
        chk("mask_dir", 32'(direction), 0);
        chk("mask_door", 32'(door_state), 0);

        // Car call to floor 5 from idle at 0.
        sb.push_back(5);
        req_floor = 8'h20;
        step(1);
        req_floor = '0;
        chk("t2_pend", 32'(pending_calls), 32'h20);
        chk("t2_dir_idle", 32'(direction), 0);
        step(1);
        chk("t2_dir_up", 32'(direction), 1);
        chk("t2_floor0", 32'(current_floor), 0);
        step(9);
        chk("t2_floor0_late", 32'(current_floor), 0);
        step(1);
        chk("t2_floor1", 32'(current_floor), 1);
        step(40);
        chk("t2_floor5", 32'(current_floor), 5);
        chk("t2_door_open", 32'(door_state), 1);
        chk("t2_dir_hold", 32'(direction), 1);
        chk("t2_pend_clr", 32'(pending_calls), 0);
        step(19);
        chk("t2_door_last", 32'(door_state), 1);
        step(1);
        chk("t2_door_closed", 32'(door_state), 0);
        chk("t2_dir_end", 32'(direction), 0);

        // Reset while travelling down past floor 3.
        req_floor = 8'h01;
        step(1);
        req_floor = '0;
        step(1);
        chk("t1_dir_down", 32'(direction), 2);
        step(20);
        chk("t1_floor3", 32'(current_floor), 3);
        step(5);
        rst = 1'b1;
        #1;
        chk("t1_rst_floor", 32'(current_floor), 0);
        chk("t1_rst_dir", 32'(direction), 0);
        chk("t1_rst_door", 32'(door_state), 0);
        chk("t1_rst_pend", 32'(pending_calls), 0);
        step(2);
        rst = 1'b0;

        // SCAN: up to 6 with hall calls picked up along the way.
        sb.push_back(4); sb.push_back(6); sb.push_back(3);
        req_floor = 8'h40;
        step(1);
        req_floor = '0;
        step(11);
        chk("t3_floor1", 32'(current_floor), 1);
        move_up_call = 8'h10; move_down_call = 8'h08;
        step(1);
        move_up_call = '0; move_down_call = '0;
        chk("t3_pend", 32'(pending_calls), 32'h58);
        step(19);
        chk("t3_pass3_floor", 32'(current_floor), 3);
        chk("t3_pass3_door", 32'(door_state), 0);
        step(10);
        chk("t3_stop4_floor", 32'(current_floor), 4);
        chk("t3_stop4_door", 32'(door_state), 1);
        step(20);
        chk("t3_close4", 32'(door_state), 0);
        chk("t3_idle4", 32'(direction), 0);
        step(1);
        chk("t3_resume_up", 32'(direction), 1);
        step(20);
        chk("t3_stop6_floor", 32'(current_floor), 6);
        chk("t3_stop6_door", 32'(door_state), 1);
        step(21);
        chk("t3_reverse", 32'(direction), 2);
        step(30);
        chk("t3_stop3_floor", 32'(current_floor), 3);
        chk("t3_stop3_door", 32'(door_state), 1);
        step(20);
        chk("t3_done_door", 32'(door_state), 0);
        chk("t3_done_pend", 32'(pending_calls), 0);

        // Door handling at floor 2: held open, close button, overload.
        sb.push_back(2);
        req_floor = 8'h04;
        step(1);
        req_floor = '0;
        step(11);
        chk("t4_floor2", 32'(current_floor), 2);
        chk("t4_open", 32'(door_state), 1);
        open_door = 1'b1;
        step(50);
        open_door = 1'b0;
        step(19);
        chk("t4_hold_open", 32'(door_state), 1);
        step(1);
        chk("t4_hold_closed", 32'(door_state), 0);

        sb.push_back(2);
        open_door = 1'b1;
        step(1);
        open_door = 1'b0;
        chk("t4_reopen", 32'(door_state), 1);
        step(2);
        chk("t4_pre_close", 32'(door_state), 1);
        close_door = 1'b1;
        step(1);
        close_door = 1'b0;
        chk("t4_close_btn", 32'(door_state), 0);

        sb.push_back(2);
        open_door = 1'b1;
        step(1);
        open_door = 1'b0;
        over_weight = 1'b1;
        chk("t4_ow_open", 32'(door_state), 1);
        step(1);
        chk("t4_alert_on", 32'(over_weight_alert), 1);
        close_door = 1'b1;
        step(30);
        chk("t4_ow_door", 32'(door_state), 1);
        chk("t4_ow_alert", 32'(over_weight_alert), 1);
        over_weight = 1'b0;
        close_door = 1'b0;
        step(1);
        chk("t4_alert_off", 32'(over_weight_alert), 0);
        chk("t4_after_ow_door", 32'(door_state), 1);
        step(19);
        chk("t4_dwell_last", 32'(door_state), 1);
        step(1);
        chk("t4_dwell_done", 32'(door_state), 0);

        // Hall call at the current floor opens the door two edges later.
        sb.push_back(2);
        move_up_call = 8'h04;
        step(1);
        move_up_call = '0;
        chk("lat_door0", 32'(door_state), 0);
        chk("lat_pend", 32'(pending_calls), 32'h04);
        step(1);
        chk("lat_door1", 32'(door_state), 1);
        chk("lat_pend_clr", 32'(pending_calls), 0);
        step(20);
        chk("lat_closed", 32'(door_state), 0);

`ifdef FIRE_RECALL_EN
        // Fire recall while moving up past 4 toward 6.
        req_floor = 8'h40;
        step(1);
        req_floor = '0;
        step(21);
        chk("fr_floor4", 32'(current_floor), 4);
        step(3);
        sb.push_back(0);
        fire_recall = 1'b1;
        step(1);
        chk("fr_pend_clr", 32'(pending_calls), 0);
        chk("fr_dir_down", 32'(direction), 2);
        for (int i = 0; i < 200 && !(door_state && current_floor == 3'd0); i++) step(1);
        chk("fr_home_open", 32'({door_state, current_floor}), 32'h8);
        step(30);
        chk("fr_held", 32'(door_state), 1);
        fire_recall = 1'b0;
        step(19);
        chk("fr_release_open", 32'(door_state), 1);
        step(1);
        chk("fr_release_closed", 32'(door_state), 0);
`endif

        chk("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
